// File: rtl/csa_pkg.sv
// csa_pkg: shared sizing constants for the 8-bit carry-select adder.
package csa_pkg;
    localparam int CSA_WIDTH = 8;
    localparam int CSA_BLOCK = 4;
    localparam int CSA_NBLK  = CSA_WIDTH / CSA_BLOCK;
endpackage

// File: rtl/rca_block.sv
// rca_block: BLOCK-bit ripple-carry adder slice with carry-in and carry-out.
module rca_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] x,
    input  logic [BLOCK-1:0] y,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, cin};
endmodule

// File: rtl/carry_select_adder_8b.sv
// carry_select_adder_8b: registered carry-select adder, {c,s} = a + b.
// Defining CSA_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module carry_select_adder_8b
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int NBLK = WIDTH / BLOCK;
    logic [WIDTH-1:0] w_a, w_b, w_sum;
    logic [NBLK:1]    w_k;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
`ifdef CSA_INPUT_REG_EN
    logic [WIDTH-1:0] r_a, r_b;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= a;
            r_b <= b;
        end
    end
    assign w_a = r_a;
    assign w_b = r_b;
`else
    assign w_a = a;
    assign w_b = b;
`endif
    // w_k[i] is the selected carry out of block i-1
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        if (g == 0) begin : g_lsb
            rca_block #(.BLOCK(BLOCK)) u_rca (
                .x(w_a[BLOCK-1:0]), .y(w_b[BLOCK-1:0]), .cin(1'b0),
                .sum(w_sum[BLOCK-1:0]), .cout(w_k[1])
            );
        end else begin : g_sel
            logic [BLOCK-1:0] w_s0, w_s1;
            logic             w_c0, w_c1;
            rca_block #(.BLOCK(BLOCK)) u_rca0 (
                .x(w_a[g*BLOCK +: BLOCK]), .y(w_b[g*BLOCK +: BLOCK]), .cin(1'b0),
                .sum(w_s0), .cout(w_c0)
            );
            rca_block #(.BLOCK(BLOCK)) u_rca1 (
                .x(w_a[g*BLOCK +: BLOCK]), .y(w_b[g*BLOCK +: BLOCK]), .cin(1'b1),
                .sum(w_s1), .cout(w_c1)
            );
            assign w_sum[g*BLOCK +: BLOCK] = w_k[g] ? w_s1 : w_s0;
            assign w_k[g+1]                = w_k[g] ? w_c1 : w_c0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= '0;
            r_c <= 1'b0;
        end else begin
            r_s <= w_sum;
            r_c <= w_k[NBLK];
        end
    end
    assign s = r_s;
    assign c = r_c;
endmodule

// File: tb/tb_carry_select_adder_8b.sv
// tb_carry_select_adder_8b: directed-table and exhaustive check of carry_select_adder_8b.
// Latency follows CSA_INPUT_REG_EN the same way the design does.
module tb_carry_select_adder_8b;
`ifdef CSA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] e;
        string      n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [7:0] s;
    logic       c;
    int         n_cmp = 0, n_bad = 0;
    logic [8:0] dq_v [LAT];
    bit         dq_ok[LAT];
    string      dq_n [LAT];
    vec_t       tv[11];

    carry_select_adder_8b dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s), .c(c));

    always #5 clk = ~clk;

    task automatic check(input logic [8:0] exp, input string nm);
        n_cmp++;
        if ({c, s} !== exp) begin
            n_bad++;
            $display("FAIL %s: got c=%0b s=%02h, want c=%0b s=%02h", nm, c, s, exp[8], exp[7:0]);
        end
    endtask

    // one clock: drive at negedge, then check #1 after the rising edge
    task automatic cyc(input logic [7:0] ia, input logic [7:0] ib, input logic irst,
                       input logic [8:0] iexp, input string nm);
        @(negedge clk);
        a = ia;
        b = ib;
        rst_n = irst;
        @(posedge clk);
        #1;
        if (!irst) begin
            check(9'h000, nm);
            for (int i = 0; i < LAT; i++) begin
                dq_v[i] = 9'h000;
                dq_ok[i] = 1'b1;
                dq_n[i] = {nm, "_flush"};
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                dq_v[i] = dq_v[i-1];
                dq_ok[i] = dq_ok[i-1];
                dq_n[i] = dq_n[i-1];
            end
            dq_v[0] = iexp;
            dq_ok[0] = 1'b1;
            dq_n[0] = nm;
            if (dq_ok[LAT-1]) check(dq_v[LAT-1], dq_n[LAT-1]);
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) dq_ok[i] = 1'b0;
        tv[0]  = '{8'hFF, 8'h01, 9'h100, "rst_release"};
        tv[1]  = '{8'd3,  8'd0,  9'd3,   "seq_3p0"};
        tv[2]  = '{8'd0,  8'd1,  9'd1,   "seq_0p1"};
        tv[3]  = '{8'd6,  8'd2,  9'd8,   "seq_6p2"};
        tv[4]  = '{8'd8,  8'd3,  9'd11,  "seq_8p3"};
        tv[5]  = '{8'd12, 8'd3,  9'd15,  "seq_12p3"};
        tv[6]  = '{8'd8,  8'd4,  9'd12,  "seq_8p4"};
        tv[7]  = '{8'h0F, 8'h01, 9'h010, "xblk_0f"};
        tv[8]  = '{8'h7F, 8'h01, 9'h080, "xblk_7f"};
        tv[9]  = '{8'hFF, 8'hFF, 9'h1FE, "ovf_ff"};
        tv[10] = '{8'h80, 8'h80, 9'h100, "ovf_80"};
        cyc(8'hFF, 8'h01, 1'b0, 9'h000, "rst_hold0");
        cyc(8'hFF, 8'h01, 1'b0, 9'h000, "rst_hold1");
        foreach (tv[i]) cyc(tv[i].a, tv[i].b, 1'b1, tv[i].e, tv[i].n);
        cyc(8'd10,  8'd20,  1'b1, 9'd30,  "mid_pre0");
        cyc(8'd100, 8'd50,  1'b1, 9'd150, "mid_pre1");
        cyc(8'd200, 8'd100, 1'b0, 9'd0,   "mid_rst");
        cyc(8'd33,  8'd44,  1'b1, 9'd77,  "mid_post0");
        cyc(8'd255, 8'd1,   1'b1, 9'h100, "mid_post1");
        cyc(8'd129, 8'd200, 1'b1, 9'd329, "mid_post2");
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] xa, xb;
            xa = i[15:8];
            xb = i[7:0];
            cyc(xa, xb, 1'b1, {1'b0, xa} + {1'b0, xb}, "exh");
        end
        for (int i = 0; i < LAT; i++) cyc(8'd0, 8'd0, 1'b1, 9'd0, "drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
